pin_edge_detect: RTL and testbench

Synchronous edge detector for one slow asynchronous input pin (button, external strobe). It samples `Pin_In` through a two-stage register chain. It emits a one-cycle `H2L_Sig` pulse on each falling edge and a one-cycle `L2H_Sig` pulse on each rising edge. An optional power-up mask suppresses pulses while the pin settles. It sits between the pad and downstream debounce or control logic; the two sampling stages are exported as `SQ_F1`/`SQ_F2` for simulation visibility.

---
 rtl/pin_edge_detect_pkg.sv | 7 +
 rtl/pin_edge_detect_if.sv | 26 ++
 rtl/pin_edge_detect.sv | 47 ++++
 tb/tb_pin_edge_detect.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/pin_edge_detect_pkg.sv
// Shared constants for the pin edge detector.
package pin_edge_detect_pkg;

  // Pad idles high, so the sampling chain resets to this level to avoid a spurious edge.
  localparam logic PIN_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/pin_edge_detect_if.sv
// Pin-side bundle: raw pin in, edge pulses and sampling-stage debug taps out.
interface pin_edge_detect_if;

  logic Pin_In;
  logic H2L_Sig;
  logic L2H_Sig;
  logic SQ_F1;
  logic SQ_F2;

  modport master (
    output Pin_In,
    input  H2L_Sig,
    input  L2H_Sig,
    input  SQ_F1,
    input  SQ_F2
  );

  modport slave (
    input  Pin_In,
    output H2L_Sig,
    output L2H_Sig,
    output SQ_F1,
    output SQ_F2
  );

endinterface

// File: rtl/pin_edge_detect.sv
// Two-flop sampler of an async idle-high pin; one-cycle H2L/L2H pulses, 1-clock latency.
// No backpressure: pulses are fire-and-forget, edges during the startup mask are dropped.
module pin_edge_detect
  import pin_edge_detect_pkg::*;
#(
  parameter int STARTUP_CYCLES = 0
) (
  input  logic             CLK,
  input  logic             RSTn,
  pin_edge_detect_if.slave pin
);

  localparam int CW = (STARTUP_CYCLES > 0) ? $clog2(STARTUP_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_END = CW'(STARTUP_CYCLES);

  logic          r_f1;
  logic          r_f2;
  logic [CW-1:0] r_cnt;
  logic          w_en;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_f1 <= PIN_IDLE_LEVEL;
      r_f2 <= PIN_IDLE_LEVEL;
    end else begin
      r_f1 <= pin.Pin_In;
      r_f2 <= r_f1;
    end
  end

  // Counter saturates at CNT_END so the enable can never drop again.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_cnt <= '0;
    end else if (r_cnt != CNT_END) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign w_en = (r_cnt == CNT_END);

  assign pin.H2L_Sig = w_en &  r_f2 & ~r_f1;
  assign pin.L2H_Sig = w_en & ~r_f2 &  r_f1;
  assign pin.SQ_F1   = r_f1;
  assign pin.SQ_F2   = r_f2;

endmodule

// File: tb/tb_pin_edge_detect.sv
// Directed bench: table of pin levels with expected pulses, plus reset and startup-mask sequences.
module tb_pin_edge_detect;

  logic CLK;
  logic rst_n0;
  logic rst_n1;

  int n_tests;
  int n_fail;

  pin_edge_detect_if u_if0 ();
  pin_edge_detect_if u_if1 ();

  pin_edge_detect #(.STARTUP_CYCLES(0)) u_dut0 (
    .CLK  (CLK),
    .RSTn (rst_n0),
    .pin  (u_if0)
  );

  pin_edge_detect #(.STARTUP_CYCLES(10)) u_dut1 (
    .CLK  (CLK),
    .RSTn (rst_n1),
    .pin  (u_if1)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic pin;
    logic h2l;
    logic l2h;
    logic f1;
    logic f2;
  } vec_t;

  vec_t vecs [17];

  function automatic vec_t mk(logic p, logic h, logic l, logic f1, logic f2);
    vec_t v;
    v.pin = p; v.h2l = h; v.l2h = l; v.f1 = f1; v.f2 = f2;
    return v;
  endfunction

  task automatic check(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;

    // pin applied before the edge, outputs expected just after it
    vecs[0]  = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    vecs[1]  = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    vecs[2]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    vecs[3]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    vecs[4]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    vecs[5]  = mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    vecs[6]  = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    vecs[7]  = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    vecs[8]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    vecs[9]  = mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    vecs[10] = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    vecs[11] = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    vecs[12] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    vecs[13] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    vecs[14] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    vecs[15] = mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    vecs[16] = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);

    rst_n0 = 1'b0;
    rst_n1 = 1'b0;
    u_if0.Pin_In = 1'b1;
    u_if1.Pin_In = 1'b1;

    // Reset with idle pin
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("rst%0d h2l", i), u_if0.H2L_Sig, 1'b0);
      check($sformatf("rst%0d l2h", i), u_if0.L2H_Sig, 1'b0);
      check($sformatf("rst%0d f1", i),  u_if0.SQ_F1,   1'b1);
      check($sformatf("rst%0d f2", i),  u_if0.SQ_F2,   1'b1);
    end
    rst_n0 = 1'b1;
    #1;
    check("rel h2l", u_if0.H2L_Sig, 1'b0);
    check("rel l2h", u_if0.L2H_Sig, 1'b0);

    // Table: falling edge, 3-cycle low, 1-cycle low, 4-cycle low
    for (int i = 0; i < 17; i++) begin
      u_if0.Pin_In = vecs[i].pin;
      step();
      check($sformatf("v%0d h2l", i), u_if0.H2L_Sig, vecs[i].h2l);
      check($sformatf("v%0d l2h", i), u_if0.L2H_Sig, vecs[i].l2h);
      check($sformatf("v%0d f1", i),  u_if0.SQ_F1,   vecs[i].f1);
      check($sformatf("v%0d f2", i),  u_if0.SQ_F2,   vecs[i].f2);
      check($sformatf("v%0d excl", i), u_if0.H2L_Sig & u_if0.L2H_Sig, 1'b0);
    end

    // Reset asserted in the middle of an H2L pulse
    u_if0.Pin_In = 1'b0;
    step();
    check("midrst pre h2l", u_if0.H2L_Sig, 1'b1);
    #2;
    rst_n0 = 1'b0;
    u_if0.Pin_In = 1'b1;
    #1;
    check("midrst h2l", u_if0.H2L_Sig, 1'b0);
    check("midrst l2h", u_if0.L2H_Sig, 1'b0);
    check("midrst f1",  u_if0.SQ_F1,   1'b1);
    check("midrst f2",  u_if0.SQ_F2,   1'b1);
    step();
    step();
    rst_n0 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("postrst%0d h2l", i), u_if0.H2L_Sig, 1'b0);
      check($sformatf("postrst%0d l2h", i), u_if0.L2H_Sig, 1'b0);
    end

    // Startup mask of 10 cycles: fall at cycle 3 masked, rise at cycle 15 reported
    step();
    rst_n1 = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      u_if1.Pin_In = (c >= 3 && c < 15) ? 1'b0 : 1'b1;
      step();
      check($sformatf("mask c%0d h2l", c), u_if1.H2L_Sig, 1'b0);
      check($sformatf("mask c%0d l2h", c), u_if1.L2H_Sig, (c == 15) ? 1'b1 : 1'b0);
      check($sformatf("mask c%0d f1", c),  u_if1.SQ_F1,   u_if1.Pin_In);
    end

    // Long idle: enable must still hold (counter saturates rather than wraps)
    for (int c = 0; c < 40; c++) step();
    u_if1.Pin_In = 1'b0;
    step();
    check("late h2l", u_if1.H2L_Sig, 1'b1);
    check("late l2h", u_if1.L2H_Sig, 1'b0);
    u_if1.Pin_In = 1'b1;
    step();
    check("late2 h2l", u_if1.H2L_Sig, 1'b0);
    check("late2 l2h", u_if1.L2H_Sig, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
